// File: rtl/lacc_mem_bridge.sv
// Bridges the CNN accelerator's lacc_data request stream onto an in-order memory bus.
// Requests are queued, outstanding bus transactions are tracked, and read data returns in order.
module lacc_mem_bridge #(
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               lacc_flush,
  input  logic                               lacc_data_valid,
  output logic                               lacc_data_ready,
  input  logic [31:0]                        lacc_data_addr,
  input  logic                               lacc_data_read,
  input  logic [31:0]                        lacc_data_wdata,
  input  logic [1:0]                         lacc_data_size,
  output logic                               lacc_drsp_valid,
  output logic [31:0]                        lacc_drsp_rdata,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [31:0]                        mem_req_addr,
  output logic                               mem_req_we,
  output logic [31:0]                        mem_req_wdata,
  output logic [3:0]                         mem_req_wstrb,
  input  logic                               mem_rsp_valid,
  input  logic [31:0]                        mem_rsp_rdata,
  input  logic                               mem_rsp_err,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_sticky
);

  localparam int QPW = $clog2(REQ_DEPTH);
  localparam int QCW = QPW + 1;
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TCW = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        read;
    logic [1:0]  size;
  } req_t;

  typedef struct packed {
    logic       is_read;
    logic [1:0] size;
    logic [1:0] offset;
    logic       discard;
  } trk_t;

  req_t           fifo_mem [REQ_DEPTH];
  logic [QPW-1:0] fifo_wr, fifo_rd;
  logic [QCW-1:0] fifo_cnt;

  trk_t           trk_mem [MAX_OUTSTANDING];
  logic [TPW-1:0] trk_wr, trk_rd;
  logic [TCW-1:0] trk_cnt;

  logic        alive;
  logic        fifo_full, trk_full;
  logic        push, issue, rsp_pop, drsp_fire;
  logic        misalign;
  req_t        head;
  trk_t        trk_head;
  logic [31:0] rsp_shift, rsp_data;

  assign head     = fifo_mem[fifo_rd];
  assign trk_head = trk_mem[trk_rd];

  assign fifo_full = (fifo_cnt == QCW'(REQ_DEPTH));
  assign trk_full  = (trk_cnt == TCW'(MAX_OUTSTANDING));

  // alive keeps ready low during reset and rises on the first edge after release.
  assign lacc_data_ready = alive & ~fifo_full & ~lacc_flush;
  assign push            = lacc_data_valid & lacc_data_ready;
  assign mem_req_valid   = (fifo_cnt != '0) & ~trk_full & ~lacc_flush;
  assign issue           = mem_req_valid & mem_req_ready;
  assign rsp_pop         = mem_rsp_valid & (trk_cnt != '0);
  assign drsp_fire       = rsp_pop & trk_head.is_read & ~trk_head.discard & ~lacc_flush;
  assign outstanding     = trk_cnt;

  assign mem_req_addr = {head.addr[31:2], 2'b00};
  assign mem_req_we   = ~head.read;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    mem_req_wstrb = 4'hF;
    mem_req_wdata = head.wdata;
    misalign      = 1'b0;
    case (head.size)
      2'd0: begin
        mem_req_wstrb = 4'b0001 << head.addr[1:0];
        mem_req_wdata = {4{head.wdata[7:0]}};
      end
      2'd1: begin
        mem_req_wstrb = 4'b0011 << {head.addr[1], 1'b0};
        mem_req_wdata = {2{head.wdata[15:0]}};
        misalign      = head.addr[0];
      end
      default: misalign = |head.addr[1:0];
    endcase
  end

  always_comb begin
    rsp_shift = mem_rsp_rdata >> {trk_head.offset, 3'b000};
    rsp_data  = rsp_shift;
    case (trk_head.size)
      2'd0:    rsp_data = {24'd0, rsp_shift[7:0]};
      2'd1:    rsp_data = {16'd0, rsp_shift[15:0]};
      default: rsp_data = rsp_shift;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else if (lacc_flush) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)  fifo_wr <= fifo_wr + QPW'(1);
      if (issue) fifo_rd <= fifo_rd + QPW'(1);
      fifo_cnt <= fifo_cnt + QCW'(push) - QCW'(issue);
    end
  end

  // NOTE: storage arrays carry no reset; the counters and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr] <= '{addr:  lacc_data_addr,
                                     wdata: lacc_data_wdata,
                                     read:  lacc_data_read,
                                     size:  lacc_data_size};
  end

  always_ff @(posedge clk) begin
    if (lacc_flush) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) trk_mem[i].discard <= 1'b1;
    end
    if (issue) trk_mem[trk_wr] <= '{is_read: head.read,
                                    size:    head.size,
                                    offset:  head.addr[1:0],
                                    discard: 1'b0};
  end

  // Tracker depth need not fill the pointer range when MAX_OUTSTANDING is 1, so wrap explicitly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_wr  <= '0;
      trk_rd  <= '0;
      trk_cnt <= '0;
    end else begin
      if (issue)   trk_wr <= (trk_wr == TPW'(MAX_OUTSTANDING - 1)) ? '0 : trk_wr + TPW'(1);
      if (rsp_pop) trk_rd <= (trk_rd == TPW'(MAX_OUTSTANDING - 1)) ? '0 : trk_rd + TPW'(1);
      trk_cnt <= trk_cnt + TCW'(issue) - TCW'(rsp_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lacc_drsp_valid <= 1'b0;
      lacc_drsp_rdata <= '0;
    end else begin
      lacc_drsp_valid <= drsp_fire;
      if (drsp_fire) lacc_drsp_rdata <= rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if ((issue & misalign) ||
                 (mem_rsp_valid & (mem_rsp_err | (trk_cnt == '0)))) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lacc_mem_bridge.sv
// Self-checking bench for lacc_mem_bridge: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a queue-based transaction model.
module tb_lacc_mem_bridge;

  localparam int REQ_DEPTH       = 4;
  localparam int MAX_OUTSTANDING = 4;

  logic        clk;
  logic        rst;
  logic        lacc_flush;
  logic        lacc_data_valid;
  logic        lacc_data_ready;
  logic [31:0] lacc_data_addr;
  logic        lacc_data_read;
  logic [31:0] lacc_data_wdata;
  logic [1:0]  lacc_data_size;
  logic        lacc_drsp_valid;
  logic [31:0] lacc_drsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic [2:0]  outstanding;
  logic        err_sticky;

  lacc_mem_bridge #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
    .clk(clk), .rst(rst), .lacc_flush(lacc_flush),
    .lacc_data_valid(lacc_data_valid), .lacc_data_ready(lacc_data_ready),
    .lacc_data_addr(lacc_data_addr), .lacc_data_read(lacc_data_read),
    .lacc_data_wdata(lacc_data_wdata), .lacc_data_size(lacc_data_size),
    .lacc_drsp_valid(lacc_drsp_valid), .lacc_drsp_rdata(lacc_drsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .outstanding(outstanding), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        read;
    logic [1:0]  size;
  } req_s;

  typedef struct {
    logic [1:0] off;
    int         n;
    bit         read;
    bit         discard;
  } infl_s;

  req_s        exp_req_q[$];   // accepted, not yet issued
  infl_s       infl_q[$];      // issued, not yet answered
  logic [31:0] rsp_todo[$];    // word addresses the bus still owes a response for
  logic [31:0] mem_m [logic [31:0]];

  bit          err_m, alive_m, drsp_due;
  logic [31:0] drsp_val;

  int          drsp_count, issue_count;
  logic [31:0] last_drsp, last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_we;
  logic [31:0] drsp_log[$];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    int base = (int'(a[1:0]) / n) * n;
    logic [3:0] s = '0;
    for (int b = 0; b < 4; b++) if (b >= base && b < base + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] d, input logic [1:0] sz);
    int n = nbytes(sz);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) o[8*b +: 8] = d[8*(b % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off, input int n);
    logic [31:0] v = d >> (8 * int'(off));
    if (n == 1) v = v & 32'h0000_00FF;
    if (n == 2) v = v & 32'h0000_FFFF;
    return v;
  endfunction

  req_s  r_tmp;
  infl_s i_tmp;
  bit    fl, exp_ready, exp_valid;

  // Model is advanced at the falling edge: compare against pre-edge state, then apply this cycle's events.
  always @(negedge clk) begin
    if (!rst) begin
      exp_req_q.delete();
      infl_q.delete();
      err_m    = 0;
      alive_m  = 0;
      drsp_due = 0;
    end else begin
      fl        = lacc_flush;
      exp_ready = alive_m && (exp_req_q.size() < REQ_DEPTH) && !fl;
      exp_valid = (exp_req_q.size() > 0) && (infl_q.size() < MAX_OUTSTANDING) && !fl;
      check("data_ready", lacc_data_ready, exp_ready);
      check("req_valid", mem_req_valid, exp_valid);
      if (exp_valid && mem_req_valid) begin
        r_tmp = exp_req_q[0];
        check("req_addr", mem_req_addr, {r_tmp.addr[31:2], 2'b00});
        check("req_we", mem_req_we, !r_tmp.read);
        check("req_wstrb", mem_req_wstrb, lanes(r_tmp.addr, r_tmp.size));
        if (!r_tmp.read) check("req_wdata", mem_req_wdata, replicate(r_tmp.wdata, r_tmp.size));
      end
      check("outstanding", outstanding, infl_q.size());
      check("err_sticky", err_sticky, err_m);
      check("drsp_valid", lacc_drsp_valid, drsp_due);
      if (drsp_due && lacc_drsp_valid) check("drsp_rdata", lacc_drsp_rdata, drsp_val);
      if (lacc_drsp_valid) begin
        drsp_count++;
        last_drsp = lacc_drsp_rdata;
        drsp_log.push_back(lacc_drsp_rdata);
      end

      drsp_due = 0;
      if (mem_rsp_valid) begin
        if (infl_q.size() == 0) err_m = 1;
        else begin
          i_tmp = infl_q.pop_front();
          if (mem_rsp_err) err_m = 1;
          if (i_tmp.read && !i_tmp.discard && !fl) begin
            drsp_due = 1;
            drsp_val = extract(mem_rsp_rdata, i_tmp.off, i_tmp.n);
          end
        end
      end
      if (fl) begin
        exp_req_q.delete();
        foreach (infl_q[i]) infl_q[i].discard = 1;
      end else begin
        if (exp_valid && mem_req_ready) begin
          r_tmp = exp_req_q.pop_front();
          infl_q.push_back('{off: r_tmp.addr[1:0], n: nbytes(r_tmp.size), read: r_tmp.read, discard: 0});
          rsp_todo.push_back({r_tmp.addr[31:2], 2'b00});
          if ((int'(r_tmp.addr[1:0]) % nbytes(r_tmp.size)) != 0) err_m = 1;
          issue_count++;
          last_addr  = mem_req_addr;
          last_we    = mem_req_we;
          last_wstrb = mem_req_wstrb;
          last_wdata = mem_req_wdata;
        end
        if (lacc_data_valid && exp_ready)
          exp_req_q.push_back('{addr: lacc_data_addr, wdata: lacc_data_wdata,
                                read: lacc_data_read, size: lacc_data_size});
      end
      alive_m = 1;
    end
  end

  // ---------------- bus responder ----------------
  bit          rsp_en = 0, orphan_req = 0, rsp_err_next = 0;
  int          rsp_rate = 100;
  logic [31:0] rsp_a;

  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_rdata = $urandom;
    if (orphan_req) begin
      mem_rsp_valid = 1'b1;
      orphan_req    = 0;
    end else if (rsp_en && rsp_todo.size() > 0 && $urandom_range(99) < rsp_rate) begin
      rsp_a         = rsp_todo.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = mem_m.exists(rsp_a) ? mem_m[rsp_a] : $urandom;
      mem_rsp_err   = rsp_err_next;
      rsp_err_next  = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [1:0] sz);
    int n = 0;
    lacc_data_valid = 1'b1;
    lacc_data_addr  = a;
    lacc_data_read  = rd;
    lacc_data_wdata = wd;
    lacc_data_size  = sz;
    while (!lacc_data_ready && n < 200) begin
      cyc(1);
      n++;
    end
    check("send_timeout", (n >= 200), 0);
    cyc(1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_req_q.size() == 0 && infl_q.size() == 0 && rsp_todo.size() == 0 && !drsp_due)
           && n < 3000) begin
      cyc(1);
      n++;
    end
    check("idle_timeout", (n >= 3000), 0);
    cyc(2);
  endtask

  task automatic do_reset();
    lacc_data_valid = 1'b0;
    lacc_flush      = 1'b0;
    rst             = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0, i0;

  initial begin
    rst             = 1'b0;
    lacc_flush      = 1'b0;
    lacc_data_valid = 1'b0;
    lacc_data_addr  = '0;
    lacc_data_read  = 1'b0;
    lacc_data_wdata = '0;
    lacc_data_size  = '0;
    mem_req_ready   = 1'b1;
    mem_m[32'h1000] = 32'hDEADBEEF;
    mem_m[32'h3000] = 32'h12345678;
    for (int i = 0; i < 8; i++) mem_m[32'h4000 + 4 * i] = 32'h100 + i;

    // Reset values
    cyc(2);
    check("rst_ready", lacc_data_ready, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_drsp_valid", lacc_drsp_valid, 0);
    check("rst_drsp_rdata", lacc_drsp_rdata, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_sticky, 0);
    rst = 1'b1;
    cyc(1);
    check("ready_after_release", lacc_data_ready, 1);
    rsp_en = 1;

    // Word read
    d0 = drsp_count;
    send(32'h1000, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t1_addr", last_addr, 32'h1000);
    check("t1_wstrb", last_wstrb, 4'hF);
    check("t1_we", last_we, 0);
    check("t1_drsp_count", drsp_count - d0, 1);
    check("t1_rdata", last_drsp, 32'hDEADBEEF);

    // Byte write
    d0 = drsp_count;
    send(32'h2003, 0, 32'hAB, 2'd0);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t2_addr", last_addr, 32'h2000);
    check("t2_wstrb", last_wstrb, 4'b1000);
    check("t2_wdata", last_wdata, 32'hABABABAB);
    check("t2_we", last_we, 1);
    check("t2_no_drsp", drsp_count - d0, 0);
    check("t2_outstanding", outstanding, 0);

    // Back-to-back reads with responses withheld until tracker and FIFO are both full
    rsp_en = 0;
    d0 = drsp_count;
    i0 = issue_count;
    drsp_log.delete();
    for (int i = 0; i < MAX_OUTSTANDING + REQ_DEPTH; i++) send(32'h4000 + 4 * i, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    cyc(3);
    check("t3_outstanding", outstanding, MAX_OUTSTANDING);
    check("t3_ready_full", lacc_data_ready, 0);
    check("t3_issued", issue_count - i0, MAX_OUTSTANDING);
    rsp_en = 1;
    wait_idle();
    check("t3_drsp_count", drsp_count - d0, MAX_OUTSTANDING + REQ_DEPTH);
    for (int k = 0; k < drsp_log.size(); k++) check("t3_order", drsp_log[k], 32'h100 + k);

    // Flush with 3 outstanding and 2 queued
    rsp_en = 0;
    d0 = drsp_count;
    i0 = issue_count;
    for (int i = 0; i < 3; i++) send(32'h4000 + 4 * i, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    cyc(2);
    mem_req_ready = 1'b0;
    send(32'h4010, 1, 0, 2'd2);
    send(32'h4014, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    cyc(2);
    check("t4_pre_outstanding", outstanding, 3);
    lacc_flush = 1'b1;
    cyc(1);
    lacc_flush    = 1'b0;
    mem_req_ready = 1'b1;
    cyc(4);
    check("t4_no_issue", issue_count - i0, 3);
    rsp_en = 1;
    wait_idle();
    check("t4_no_drsp", drsp_count - d0, 0);
    check("t4_outstanding", outstanding, 0);
    send(32'h1000, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t4_post_count", drsp_count - d0, 1);
    check("t4_post_rdata", last_drsp, 32'hDEADBEEF);

    // Half reads: aligned, then misaligned
    send(32'h3002, 1, 0, 2'd1);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t5_half_rdata", last_drsp, 32'h00001234);
    check("t5_err_clear", err_sticky, 0);
    send(32'h3001, 1, 0, 2'd1);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t5_misalign_err", err_sticky, 1);

    // Orphan response, then an error response that still forwards data
    do_reset();
    d0 = drsp_count;
    orphan_req = 1;
    cyc(4);
    check("t6_orphan_err", err_sticky, 1);
    check("t6_orphan_no_drsp", drsp_count - d0, 0);
    do_reset();
    check("t6_reset_err", err_sticky, 0);
    rsp_err_next = 1;
    send(32'h1000, 1, 0, 2'd2);
    lacc_data_valid = 1'b0;
    wait_idle();
    check("t6_rsp_err", err_sticky, 1);
    check("t6_err_fwd_count", drsp_count - d0, 1);
    check("t6_err_fwd_rdata", last_drsp, 32'hDEADBEEF);

    // Randomized traffic with occasional flushes and bus stalls
    do_reset();
    rsp_en = 1;
    for (int c = 0; c < 800; c++) begin
      lacc_data_valid = ($urandom_range(2) != 0);
      lacc_data_addr  = 32'h5000 + $urandom_range(63);
      lacc_data_read  = $urandom_range(1);
      lacc_data_wdata = $urandom;
      lacc_data_size  = 2'($urandom_range(3));
      mem_req_ready   = ($urandom_range(3) != 0);
      lacc_flush      = ($urandom_range(39) == 0);
      rsp_rate        = (c < 400) ? 70 : 30;
      cyc(1);
    end
    lacc_data_valid = 1'b0;
    lacc_flush      = 1'b0;
    mem_req_ready   = 1'b1;
    rsp_rate        = 100;
    wait_idle();

    // Asynchronous reset in the middle of a burst
    rsp_en = 0;
    d0 = drsp_count;
    for (int i = 0; i < 3; i++) send(32'h4000 + 4 * i, 1, 0, 2'd2);
    check("t8_pre_outstanding", (outstanding != 0), 1);
    lacc_data_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t8_async_ready", lacc_data_ready, 0);
    check("t8_async_req_valid", mem_req_valid, 0);
    check("t8_async_drsp_valid", lacc_drsp_valid, 0);
    check("t8_async_drsp_rdata", lacc_drsp_rdata, 0);
    check("t8_async_outstanding", outstanding, 0);
    check("t8_async_err", err_sticky, 0);
    cyc(1);
    rst    = 1'b1;
    rsp_en = 1;
    wait_idle();
    check("t8_orphan_err", err_sticky, 1);
    check("t8_no_drsp", drsp_count - d0, 0);
    check("t8_outstanding", outstanding, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
